// File: rtl/channel_select_debounce_if.sv
// Consumer-facing channel selection bundle: debounced switch vector, decoded channel,
// change/overrun pulses and the valid/ready acknowledge pair.
interface channel_select_debounce_if;
  logic [7:0] sw_stable;
  logic [2:0] chan_sel;
  logic       chan_none;
  logic       chan_changed;
  logic       chan_valid;
  logic       chan_ready;
  logic       overrun;

  modport master (
    output sw_stable,
    output chan_sel,
    output chan_none,
    output chan_changed,
    output chan_valid,
    output overrun,
    input  chan_ready
  );

  modport slave (
    input  sw_stable,
    input  chan_sel,
    input  chan_none,
    input  chan_changed,
    input  chan_valid,
    input  overrun,
    output chan_ready
  );
endinterface

// File: rtl/channel_select_debounce.sv
// Debounces an 8-bit DIP-switch bank and presents the highest set switch as a channel
// index with a valid/ready handoff to the display stage.
module channel_select_debounce #(
  parameter int unsigned DB_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 sw_in,
  channel_select_debounce_if.master  chan
);

  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  SETTLE   = 1'b1;
  localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

  logic [7:0]  sync1, sync2, cand;
  logic [15:0] cnt;
  logic [0:0]  state;

  logic [7:0]  sw_stable_q;
  logic [2:0]  chan_sel_q;
  logic        chan_none_q;
  logic        chan_changed_q;
  logic        chan_valid_q;
  logic        overrun_q;

  logic [0:0]  state_d;
  logic [7:0]  cand_d;
  logic [15:0] cnt_d;
  logic        commit;
  logic        commit_chg;
  logic [2:0]  cand_sel;

  function automatic logic [2:0] highest_bit(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (sync2 != cand) begin
          cand_d  = sync2;
          cnt_d   = 16'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2 != cand) begin
          // Glitch during settling restarts the window on the new value.
          cand_d = sync2;
          cnt_d  = 16'd0;
        end else if (cnt < CNT_LAST) begin
          cnt_d = cnt + 16'd1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit_chg = commit && (cand != sw_stable_q);
  assign cand_sel   = highest_bit(cand);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1          <= 8'd0;
      sync2          <= 8'd0;
      cand           <= 8'd0;
      cnt            <= 16'd0;
      state          <= IDLE;
      sw_stable_q    <= 8'd0;
      chan_sel_q     <= 3'd0;
      chan_none_q    <= 1'b1;
      chan_changed_q <= 1'b0;
      chan_valid_q   <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      cand  <= cand_d;
      cnt   <= cnt_d;
      state <= state_d;
      if (commit_chg) begin
        sw_stable_q <= cand;
        chan_sel_q  <= cand_sel;
        chan_none_q <= (cand == 8'd0);
      end
      chan_changed_q <= commit_chg;
      // A fresh commit keeps valid high even if the old selection is acked this edge.
      chan_valid_q   <= commit_chg | (chan_valid_q & ~chan.chan_ready);
      overrun_q      <= commit_chg & chan_valid_q & ~chan.chan_ready;
    end
  end

  assign chan.sw_stable    = sw_stable_q;
  assign chan.chan_sel     = chan_sel_q;
  assign chan.chan_none    = chan_none_q;
  assign chan.chan_changed = chan_changed_q;
  assign chan.chan_valid   = chan_valid_q;
  assign chan.overrun      = overrun_q;

endmodule
